// File: rtl/idu_decode_queue_if.sv
//------------------------------------------------------------------------------
// Module   : idu_decode_queue_if
// Purpose  : Bus bundle between the IFU, the decode queue and the EXU.
//            'slave' is the decode-queue side; 'master' is the IFU/EXU side
//            that pushes instructions and consumes decoded bundles.
// Signals  : i_valid/o_ready/i_inst/i_pc    - IFU push side
//            o_valid/i_ready/i_flush        - EXU pop side and redirect
//            o_pc .. o_ebreak               - head decoded bundle
//            o_cnt_dec/o_cnt_ill/o_cnt_stall - saturating perf counters
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface idu_decode_queue_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_inst;
  logic [PC_W-1:0]  i_pc;
  logic             o_valid;
  logic             i_ready;
  logic             i_flush;
  logic [PC_W-1:0]  o_pc;
  logic [31:0]      o_inst;
  logic [2:0]       o_extopt;
  logic [1:0]       o_reg_sel;
  logic             o_reg_wena;
  logic             o_mem_wr;
  logic             o_mem_re;
  logic [2:0]       o_mem_op;
  logic             o_pc_sel;
  logic [2:0]       o_branch;
  logic             o_alu_asrc;
  logic [1:0]       o_alu_bsrc;
  logic [3:0]       o_alu_ctr;
  logic             o_mdu_en;
  logic [2:0]       o_mdu_op;
  logic             o_illegal;
  logic             o_ebreak;
  logic [CNT_W-1:0] o_cnt_dec;
  logic [CNT_W-1:0] o_cnt_ill;
  logic [CNT_W-1:0] o_cnt_stall;

  modport slave (
    input  i_valid, i_inst, i_pc, i_ready, i_flush,
    output o_ready, o_valid, o_pc, o_inst, o_extopt, o_reg_sel, o_reg_wena,
           o_mem_wr, o_mem_re, o_mem_op, o_pc_sel, o_branch, o_alu_asrc,
           o_alu_bsrc, o_alu_ctr, o_mdu_en, o_mdu_op, o_illegal, o_ebreak,
           o_cnt_dec, o_cnt_ill, o_cnt_stall
  );

  modport master (
    output i_valid, i_inst, i_pc, i_ready, i_flush,
    input  o_ready, o_valid, o_pc, o_inst, o_extopt, o_reg_sel, o_reg_wena,
           o_mem_wr, o_mem_re, o_mem_op, o_pc_sel, o_branch, o_alu_asrc,
           o_alu_bsrc, o_alu_ctr, o_mdu_en, o_mdu_op, o_illegal, o_ebreak,
           o_cnt_dec, o_cnt_ill, o_cnt_stall
  );
endinterface

`default_nettype wire

// File: rtl/idu_decode_queue.sv
//------------------------------------------------------------------------------
// Module   : idu_decode_queue
// Purpose  : RV32I (+CSR/ecall/ebreak/mret) decoder feeding a DEPTH-entry
//            queue of registered control bundles, with illegal-instruction
//            detection and saturating performance counters.
// Ports    : i_clk   - clock
//            i_rst   - asynchronous reset, active-low
//            bus     - idu_decode_queue_if.slave (push, pop, head bundle,
//                      flush and counters)
// Options  : IDU_RV32M_EN - decode the RV32M op group (funct7 0000001)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module idu_decode_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
) (
  input wire logic          i_clk,
  input wire logic          i_rst,
  idu_decode_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_COPYB = 4'b0011;
  localparam logic [3:0] ALU_SRA   = 4'b1101;

  typedef struct packed {
    logic [2:0] extopt;
    logic [1:0] reg_sel;
    logic       reg_wena;
    logic       mem_wr;
    logic       mem_re;
    logic [2:0] mem_op;
    logic       pc_sel;
    logic [2:0] branch;
    logic       alu_asrc;
    logic [1:0] alu_bsrc;
    logic [3:0] alu_ctr;
    logic       mdu_en;
    logic [2:0] mdu_op;
    logic       illegal;
    logic       ebreak;
  } bundle_t;

  // funct3 maps straight onto the ALU code except sltu, which sets bit 3.
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
    return (f3 == 3'b011) ? ALU_SLTU : {1'b0, f3};
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  bundle_t     dec;
  logic        bad;

  assign opcode = bus.i_inst[6:0];
  assign funct3 = bus.i_inst[14:12];
  assign funct7 = bus.i_inst[31:25];
  assign imm12  = bus.i_inst[31:20];

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.extopt = 3'b001; dec.reg_wena = 1'b1;
        dec.alu_bsrc = 2'b01; dec.alu_ctr = ALU_COPYB;
      end
      OPC_AUIPC: begin
        dec.extopt = 3'b001; dec.reg_wena = 1'b1;
        dec.alu_asrc = 1'b1; dec.alu_bsrc = 2'b01;
      end
      OPC_JAL: begin
        dec.extopt = 3'b100; dec.reg_wena = 1'b1; dec.branch = 3'b001;
        dec.alu_asrc = 1'b1; dec.alu_bsrc = 2'b10;
      end
      OPC_JALR: begin
        dec.reg_wena = 1'b1; dec.branch = 3'b010;
        dec.alu_asrc = 1'b1; dec.alu_bsrc = 2'b10;
      end
      OPC_BRANCH: begin
        dec.extopt  = 3'b011;
        dec.alu_ctr = funct3[1] ? ALU_SLTU : ALU_SLT;
        case (funct3)
          3'b000:         dec.branch = 3'b100;
          3'b001:         dec.branch = 3'b101;
          3'b100, 3'b110: dec.branch = 3'b110;
          3'b101, 3'b111: dec.branch = 3'b111;
          default:        bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.reg_sel = 2'b01; dec.reg_wena = 1'b1; dec.mem_re = 1'b1;
        dec.mem_op = funct3; dec.alu_bsrc = 2'b01;
        case (funct3)
          3'b011, 3'b110, 3'b111: bad = 1'b1;
          default: ;
        endcase
      end
      OPC_STORE: begin
        dec.extopt = 3'b010; dec.mem_wr = 1'b1;
        dec.mem_op = funct3; dec.alu_bsrc = 2'b01;
        bad = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec.reg_wena = 1'b1; dec.alu_bsrc = 2'b01;
        dec.alu_ctr = alu_of_f3(funct3);
        // Shift-immediates carry their variant in inst[31:26].
        if (funct3 == 3'b001) begin
          bad = (bus.i_inst[31:26] != 6'b000000);
        end else if (funct3 == 3'b101) begin
          if (bus.i_inst[31:26] == 6'b010000) dec.alu_ctr = ALU_SRA;
          else if (bus.i_inst[31:26] != 6'b000000) bad = 1'b1;
        end
      end
      OPC_OP: begin
        dec.reg_wena = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_ctr = alu_of_f3(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.alu_ctr = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_ctr = ALU_SRA;
            else                       bad = 1'b1;
          end
`ifdef IDU_RV32M_EN
          7'b0000001: begin
            dec.mdu_en = 1'b1; dec.mdu_op = funct3; dec.alu_ctr = ALU_ADD;
          end
`endif
          default: bad = 1'b1;
        endcase
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          case (imm12)
            12'h000: dec.pc_sel = 1'b1;  // ecall
            12'h001: dec.ebreak = 1'b1;
            12'h302: dec.pc_sel = 1'b1;  // mret
            default: bad = 1'b1;
          endcase
        end else if (funct3 == 3'b100) begin
          bad = 1'b1;
        end else begin
          dec.reg_wena = 1'b1; dec.reg_sel = 2'b10;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
  end

  // Queue storage and control
  bundle_t         bun_mem  [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;
  bundle_t         head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.i_valid && !full;
  assign pop   = !empty && bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (push && !bus.i_flush) begin
      bun_mem[wr_ptr]  <= dec;
      pc_mem[wr_ptr]   <= bus.i_pc;
      inst_mem[wr_ptr] <= bus.i_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  assign head = empty ? '0 : bun_mem[rd_ptr];

  assign bus.o_ready    = !full;
  assign bus.o_valid    = !empty;
  assign bus.o_pc       = empty ? '0 : pc_mem[rd_ptr];
  assign bus.o_inst     = empty ? '0 : inst_mem[rd_ptr];
  assign bus.o_extopt   = head.extopt;
  assign bus.o_reg_sel  = head.reg_sel;
  assign bus.o_reg_wena = head.reg_wena;
  assign bus.o_mem_wr   = head.mem_wr;
  assign bus.o_mem_re   = head.mem_re;
  assign bus.o_mem_op   = head.mem_op;
  assign bus.o_pc_sel   = head.pc_sel;
  assign bus.o_branch   = head.branch;
  assign bus.o_alu_asrc = head.alu_asrc;
  assign bus.o_alu_bsrc = head.alu_bsrc;
  assign bus.o_alu_ctr  = head.alu_ctr;
  assign bus.o_mdu_en   = head.mdu_en;
  assign bus.o_mdu_op   = head.mdu_op;
  assign bus.o_illegal  = head.illegal;
  assign bus.o_ebreak   = head.ebreak;

  // Performance counters; a pop swallowed by a flush does not count.
  logic [CNT_W-1:0] cnt_dec, cnt_ill, cnt_stall;
  logic             pop_cnt, stall;

  assign pop_cnt = pop && !bus.i_flush;
  assign stall   = !empty && !bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_dec   <= '0;
      cnt_ill   <= '0;
      cnt_stall <= '0;
    end else begin
      if (pop_cnt && cnt_dec != '1)                cnt_dec   <= cnt_dec + CNT_W'(1);
      if (pop_cnt && head.illegal && cnt_ill != '1) cnt_ill   <= cnt_ill + CNT_W'(1);
      if (stall && cnt_stall != '1)                cnt_stall <= cnt_stall + CNT_W'(1);
    end
  end

  assign bus.o_cnt_dec   = cnt_dec;
  assign bus.o_cnt_ill   = cnt_ill;
  assign bus.o_cnt_stall = cnt_stall;

endmodule

`default_nettype wire

// File: tb/tb_idu_decode_queue.sv
//------------------------------------------------------------------------------
// Module   : tb_idu_decode_queue
// Purpose  : Self-checking bench for idu_decode_queue. A 32-bit-counter DUT
//            and a 2-bit-counter DUT share the same stimulus; both are
//            compared every cycle against a queue model whose decoder is a
//            mask/match instruction table.
// Options  : IDU_RV32M_EN - expect the RV32M op group to decode
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_idu_decode_queue;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idu_decode_queue_if #(.PC_W(32), .CNT_W(32)) bus ();
  idu_decode_queue_if #(.PC_W(32), .CNT_W(2))  bus2 ();

  idu_decode_queue #(.DEPTH(DEPTH), .CNT_W(32), .PC_W(32)) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus)
  );
  idu_decode_queue #(.DEPTH(DEPTH), .CNT_W(2), .PC_W(32)) dut_sat (
    .i_clk(clk), .i_rst(rst_n), .bus(bus2)
  );

  assign bus2.i_valid = bus.i_valid;
  assign bus2.i_ready = bus.i_ready;
  assign bus2.i_flush = bus.i_flush;
  assign bus2.i_inst  = bus.i_inst;
  assign bus2.i_pc    = bus.i_pc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected bundle layout: {extopt, reg_sel, reg_wena, mem_wr, mem_re,
  // mem_op, pc_sel, branch, alu_asrc, alu_bsrc, alu_ctr, mdu_en, mdu_op,
  // illegal, ebreak}
  localparam logic [27:0] ILLEGAL = 28'd2;

  function automatic logic [27:0] mk(input logic [2:0] ext, input logic [1:0] sel,
      input logic wena, input logic wr, input logic re, input logic [2:0] mop,
      input logic pcs, input logic [2:0] br, input logic as, input logic [1:0] bs,
      input logic [3:0] ctr, input logic eb);
    return {ext, sel, wena, wr, re, mop, pcs, br, as, bs, ctr, 1'b0, 3'b000, 1'b0, eb};
  endfunction

  typedef struct { logic [31:0] mask; logic [31:0] match; logic [27:0] exp; } pat_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  pat_t pats[$];
  ent_t q[$];
  int unsigned cnt_dec, cnt_ill, cnt_stall;
  logic last_acc;

  localparam logic [31:0] M_OPC  = 32'h0000007F;
  localparam logic [31:0] M_F3   = 32'h0000707F;
  localparam logic [31:0] M_F7   = 32'hFE00707F;
  localparam logic [31:0] M_SH   = 32'hFC00707F;
  localparam logic [31:0] M_SYS  = 32'hFFF0707F;
  localparam logic [31:0] M_MDU  = 32'hFE00007F;
  localparam logic [31:0] MT_MDU = 32'h02000033;

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic [27:0] e);
    pat_t p;
    p.mask = mask; p.match = match; p.exp = e;
    pats.push_back(p);
  endtask

  task automatic build_table();
    logic [2:0] f;
    logic [2:0] br;
    add(M_OPC, 32'h37, mk(3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0011, 1'b0)); // lui
    add(M_OPC, 32'h17, mk(3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 2'd1, 4'b0000, 1'b0)); // auipc
    add(M_OPC, 32'h6F, mk(3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 2'd2, 4'b0000, 1'b0)); // jal
    add(M_OPC, 32'h67, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 2'd2, 4'b0000, 1'b0)); // jalr
    add(M_OPC, 32'h0F, 28'd0);                                                                         // fence
    for (int i = 0; i < 8; i++) begin
      f = 3'(i);
      if (i == 2 || i == 3) continue;
      br = (i == 0) ? 3'b100 : (i == 1) ? 3'b101 : (i == 4 || i == 6) ? 3'b110 : 3'b111;
      add(M_F3, {17'd0, f, 12'h063},
          mk(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, br, 1'b0, 2'd0, (i >= 6) ? 4'b1010 : 4'b0010, 1'b0));
    end
    for (int i = 0; i < 8; i++) begin
      f = 3'(i);
      if (i != 3 && i != 6 && i != 7)
        add(M_F3, {17'd0, f, 12'h003}, mk(3'd0, 2'd1, 1'b1, 1'b0, 1'b1, f, 1'b0, 3'd0, 1'b0, 2'd1, 4'd0, 1'b0));
      if (i <= 2)
        add(M_F3, {17'd0, f, 12'h023}, mk(3'd2, 2'd0, 1'b0, 1'b1, 1'b0, f, 1'b0, 3'd0, 1'b0, 2'd1, 4'd0, 1'b0));
      if (i != 0 && i != 4)
        add(M_F3, {17'd0, f, 12'h073}, mk(3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'd0, 1'b0));
    end
    add(M_F3, 32'h0013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0000, 1'b0)); // addi
    add(M_F3, 32'h2013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0010, 1'b0)); // slti
    add(M_F3, 32'h3013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b1010, 1'b0)); // sltiu
    add(M_F3, 32'h4013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0100, 1'b0)); // xori
    add(M_F3, 32'h6013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0110, 1'b0)); // ori
    add(M_F3, 32'h7013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0111, 1'b0)); // andi
    add(M_SH, 32'h1013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0001, 1'b0)); // slli
    add(M_SH, 32'h5013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b0101, 1'b0)); // srli
    add(M_SH, 32'h40005013, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd1, 4'b1101, 1'b0)); // srai
    add(M_F7, 32'h0033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0000, 1'b0)); // add
    add(M_F7, 32'h40000033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b1000, 1'b0)); // sub
    add(M_F7, 32'h1033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0001, 1'b0)); // sll
    add(M_F7, 32'h2033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0010, 1'b0)); // slt
    add(M_F7, 32'h3033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b1010, 1'b0)); // sltu
    add(M_F7, 32'h4033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0100, 1'b0)); // xor
    add(M_F7, 32'h5033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0101, 1'b0)); // srl
    add(M_F7, 32'h40005033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b1101, 1'b0)); // sra
    add(M_F7, 32'h6033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0110, 1'b0)); // or
    add(M_F7, 32'h7033, mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0111, 1'b0)); // and
    add(M_SYS, 32'h00000073, mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 2'd0, 4'd0, 1'b0)); // ecall
    add(M_SYS, 32'h00100073, mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'd0, 1'b1)); // ebreak
    add(M_SYS, 32'h30200073, mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 2'd0, 4'd0, 1'b0)); // mret
  endtask

  function automatic logic [27:0] ref_decode(input logic [31:0] w);
    logic [27:0] r;
    logic found;
    r = ILLEGAL;
    found = 1'b0;
`ifdef IDU_RV32M_EN
    if ((w & M_MDU) == MT_MDU) begin
      r = mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 4'd0, 1'b0)
          | {22'd0, 1'b1, w[14:12], 2'b00};
      found = 1'b1;
    end
`endif
    foreach (pats[i]) begin
      if (!found && (w & pats[i].mask) == pats[i].match) begin
        r = pats[i].exp;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] gen_inst();
    int unsigned sel;
    int unsigned k;
    logic [31:0] r;
    sel = $urandom_range(0, 99);
    r = $urandom;
    if (sel < 60) begin
      k = $urandom_range(0, pats.size() - 1);
      return (r & ~pats[k].mask) | pats[k].match;
    end else if (sel < 70) begin
      return (r & ~M_MDU) | MT_MDU;
    end else if (sel < 88) begin
      k = $urandom_range(0, 10);
      return {r[31:7], opcs[k]};
    end
    return r;
  endfunction

  function automatic int unsigned sat3(input int unsigned x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic compare_all();
    logic [27:0] eb;
    logic [31:0] epc, einst;
    eb = 28'd0; epc = 32'd0; einst = 32'd0;
    if (q.size() != 0) begin
      eb = ref_decode(q[0].inst);
      epc = q[0].pc;
      einst = q[0].inst;
    end
    check_eq("valid", 64'(bus.o_valid), 64'(q.size() != 0));
    check_eq("ready", 64'(bus.o_ready), 64'(q.size() < DEPTH));
    check_eq("pc", 64'(bus.o_pc), 64'(epc));
    check_eq("inst", 64'(bus.o_inst), 64'(einst));
    check_eq("bundle", 64'({bus.o_extopt, bus.o_reg_sel, bus.o_reg_wena, bus.o_mem_wr,
                            bus.o_mem_re, bus.o_mem_op, bus.o_pc_sel, bus.o_branch,
                            bus.o_alu_asrc, bus.o_alu_bsrc, bus.o_alu_ctr, bus.o_mdu_en,
                            bus.o_mdu_op, bus.o_illegal, bus.o_ebreak}), 64'(eb));
    check_eq("cnt_dec", 64'(bus.o_cnt_dec), 64'(cnt_dec));
    check_eq("cnt_ill", 64'(bus.o_cnt_ill), 64'(cnt_ill));
    check_eq("cnt_stall", 64'(bus.o_cnt_stall), 64'(cnt_stall));
    check_eq("sat_valid", 64'(bus2.o_valid), 64'(q.size() != 0));
    check_eq("sat_cnt_dec", 64'(bus2.o_cnt_dec), 64'(sat3(cnt_dec)));
    check_eq("sat_cnt_ill", 64'(bus2.o_cnt_ill), 64'(sat3(cnt_ill)));
    check_eq("sat_cnt_stall", 64'(bus2.o_cnt_stall), 64'(sat3(cnt_stall)));
  endtask

  // One cycle: check the current state, drive new inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic rdy, input logic fl);
    logic do_push, do_pop;
    logic [27:0] hb;
    ent_t e;
    @(negedge clk);
    compare_all();
    bus.i_valid = v; bus.i_inst = ins; bus.i_pc = p; bus.i_ready = rdy; bus.i_flush = fl;
    do_push = v && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && rdy;
    if ((q.size() != 0) && !rdy) cnt_stall++;
    last_acc = do_push && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) begin
        hb = ref_decode(q[0].inst);
        cnt_dec++;
        if (hb == ILLEGAL) cnt_ill++;
        void'(q.pop_front());
      end
      if (do_push) begin
        e.pc = p; e.inst = ins;
        q.push_back(e);
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_flush = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    cnt_dec = 0; cnt_ill = 0; cnt_stall = 0;
    #1;
    check_eq("async_rst_valid", 64'(bus.o_valid), 64'd0);
    check_eq("async_rst_cnt_dec", 64'(bus.o_cnt_dec), 64'd0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] SW   = 32'h0020a023;
  localparam logic [31:0] MUL  = 32'h022081B3;

  initial begin
    logic [31:0] cur_inst, cur_pc;
    logic v;
    build_table();
    cnt_dec = 0; cnt_ill = 0; cnt_stall = 0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_flush = 1'b0;
    bus.i_inst = 32'd0; bus.i_pc = 32'd0;
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // addi at the reset vector, consumed immediately
    step(1'b1, ADDI, 32'h80000000, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // fill with the consumer stalled, then drain in order
    step(1'b1, ADDI, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00100113, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h8, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h8, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h8, 1'b1, 1'b0);
    step(1'b1, 32'h00200193, 32'h8, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // flush with a concurrent push and pop
    step(1'b1, BNE, 32'h100, 1'b0, 1'b0);
    step(1'b1, SW, 32'h104, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, ADDI, 32'h108, 1'b1, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // illegal word and mul
    step(1'b1, 32'hFFFFFFFF, 32'h200, 1'b0, 1'b0);
    step(1'b1, MUL, 32'h204, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // push-and-pop streaming; drives the 2-bit counters well past saturation
    for (int i = 0; i < 5; i++) step(1'b1, ADDI, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // asynchronous reset with a bundle queued
    step(1'b1, ADDI, 32'h300, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    async_reset();

    // randomized traffic; an unaccepted instruction stays presented
    cur_inst = gen_inst();
    cur_pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      step(v, cur_inst, cur_pc, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      if (last_acc) begin
        cur_inst = gen_inst();
        cur_pc = cur_pc + 32'd4;
      end
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
